ecc_55_enc_pipe: RTL

ECC_55_ENC_PIPE -- requirements
Module: ecc_55_enc_pipe

---
 rtl/ecc_55_enc_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ecc_55_enc_pipe.sv
// SECDED (62,55) encoder with a skid-buffered output stage and error injection.
// Ports: in_* valid/ready/data, out_* valid/ready/data/parity, inj_* control, enc_cnt.
module ecc_55_enc_pipe #(
  parameter int DATA_WIDTH   = 55,
  parameter int PARITY_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_parity,
  input  logic                    inj_en,
  input  logic [1:0]              inj_mode,
  input  logic [5:0]              inj_pos,
  output logic                    inj_done,
  output logic                    inj_err,
  output logic [15:0]             enc_cnt
);

  localparam int CW = DATA_WIDTH + PARITY_WIDTH;

  typedef enum logic [0:0] {
    IDLE,
    ARMED
  } inj_state_t;

  // Walk Hamming positions 3..61, skipping powers of two; data bit idx
  // lands on position h. p[6] makes every column weight odd.
  function automatic logic [6:0] calc_par(input logic [54:0] d);
    logic [6:0] p;
    logic [5:0] h;
    logic [5:0] idx;
    p   = '0;
    idx = '0;
    for (int n = 3; n < 62; n++) begin
      h = 6'(n);
      if ((h & (h - 6'd1)) != 6'd0) begin
        for (int k = 0; k < 6; k++) begin
          if (h[k]) p[k] = p[k] ^ d[idx];
        end
        if (!(^h)) p[6] = p[6] ^ d[idx];
        idx = idx + 6'd1;
      end
    end
    return p;
  endfunction

  inj_state_t st_q, st_d;
  logic [1:0] mode_q, mode_d;
  logic [5:0] pos_q, pos_d;

  logic                  m_valid;
  logic [CW-1:0]         m_cw;
  logic                  s_valid;
  logic [CW-1:0]         s_cw;
  logic                  s_valid_d;
  logic                  ready_q;

  logic                  accept;
  logic                  drain_ok;
  logic                  pos_ok;
  logic [5:0]            pos2;
  logic [CW-1:0]         flip;
  logic [CW-1:0]         cw;

  assign accept   = in_valid & ready_q;
  assign drain_ok = ~m_valid | out_ready;
  assign pos_ok   = (pos_q <= 6'd61);

  assign in_ready   = ready_q;
  assign out_valid  = m_valid;
  assign out_data   = m_cw[DATA_WIDTH-1:0];
  assign out_parity = m_cw[CW-1:DATA_WIDTH];

  // Second bit of a double flip wraps from 61 back to data bit 0.
  always_comb begin
    flip = '0;
    pos2 = (pos_q == 6'd61) ? 6'd0 : pos_q + 6'd1;
    if (st_q == ARMED && pos_ok) begin
      flip[pos_q] = 1'b1;
      if (mode_q == 2'b10) flip[pos2] = 1'b1;
    end
  end

  assign cw = {calc_par(in_data), in_data} ^ flip;

  always_comb begin
    st_d     = st_q;
    mode_d   = mode_q;
    pos_d    = pos_q;
    inj_done = 1'b0;
    inj_err  = 1'b0;
    if (st_q == ARMED && accept) begin
      st_d     = IDLE;
      inj_done = pos_ok;
      inj_err  = ~pos_ok;
    end
    // A fresh request wins over consumption of the old one.
    if (inj_en && (inj_mode == 2'b01 || inj_mode == 2'b10)) begin
      st_d   = ARMED;
      mode_d = inj_mode;
      pos_d  = inj_pos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      mode_q <= 2'b00;
      pos_q  <= 6'd0;
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      pos_q  <= pos_d;
    end
  end

  // Skid fills only when main is stalled; in_ready blocks accept while full.
  always_comb begin
    s_valid_d = 1'b0;
    if (!drain_ok) s_valid_d = s_valid | accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cw    <= '0;
      s_valid <= 1'b0;
      s_cw    <= '0;
      ready_q <= 1'b0;
      enc_cnt <= 16'd0;
    end else begin
      unique case (1'b1)
        drain_ok && s_valid: begin
          m_valid <= 1'b1;
          m_cw    <= s_cw;
        end
        drain_ok && !s_valid && accept: begin
          m_valid <= 1'b1;
          m_cw    <= cw;
        end
        drain_ok && !s_valid && !accept: begin
          m_valid <= 1'b0;
        end
        !drain_ok && accept: begin
          s_cw <= cw;
        end
        default: ;
      endcase
      s_valid <= s_valid_d;
      ready_q <= ~s_valid_d;
      if (accept) enc_cnt <= enc_cnt + 16'd1;
    end
  end

endmodule
